// File: rtl/synth_filter_pkg.sv
// Shared types and saturating helpers for the modulated moving-average filter.
// The helpers work on longint so one definition serves every instance width.
package synth_filter_pkg;

  typedef enum logic [1:0] {
    BYPASS  = 2'd0,
    LPF     = 2'd1,
    HPF     = 2'd2,
    BYPASS2 = 2'd3
  } filt_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    UPDATE = 3'd2,
    RECALC = 3'd3,
    OUT    = 3'd4
  } filt_state_e;

  // Clamp to the range of a w-bit two's-complement value.
  function automatic longint clamp_s(input longint x, input int unsigned w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Clamp to [0, 2^w - 1].
  function automatic longint clamp_u(input longint x, input int unsigned w);
    longint hi;
    hi = (longint'(1) <<< w) - 1;
    if (x > hi) return hi;
    if (x < 0) return 0;
    return x;
  endfunction

  function automatic longint sat_add(input longint a, input longint b, input int unsigned w);
    return clamp_s(a + b, w);
  endfunction

endpackage

// File: rtl/cutoff_modulator.sv
// Builds the effective cutoff from base cutoff, envelope and LFO terms and
// maps its top bits onto a power-of-two moving-average window length.
module cutoff_modulator
  import synth_filter_pkg::*;
#(
  parameter int CTRL_W         = 16,
  parameter int MAX_LOG2_DEPTH = 6
) (
  input  logic [CTRL_W-1:0]                          cutoff_freq,
  input  logic [CTRL_W-1:0]                          eg_amount,
  input  logic [CTRL_W-1:0]                          envelope,
  input  logic [CTRL_W-1:0]                          modulation,
  output logic [$clog2(MAX_LOG2_DEPTH+1)-1:0]        new_log2
);

  localparam int KW = $clog2(MAX_LOG2_DEPTH + 1);

  logic [2*CTRL_W-1:0]      eg_prod;
  logic [CTRL_W-1:0]        eg_term;
  // One bit beyond the nominal sign+carry so the worst-case sum cannot wrap.
  logic signed [CTRL_W+2:0] raw_cut;
  logic [CTRL_W-1:0]        cut_eff;
  logic [KW-1:0]            k;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    eg_prod  = eg_amount * envelope;
    eg_term  = CTRL_W'(eg_prod >> CTRL_W);
    raw_cut  = $signed({3'b000, cutoff_freq}) + $signed({3'b000, eg_term})
             + $signed({{3{modulation[CTRL_W-1]}}, modulation});
    cut_eff  = CTRL_W'(clamp_u(longint'(raw_cut), CTRL_W));
    k        = KW'(cut_eff >> (CTRL_W - KW));
    new_log2 = '0;
    if (k < KW'(MAX_LOG2_DEPTH)) new_log2 = KW'(MAX_LOG2_DEPTH) - k;
  end

endmodule

// File: rtl/modulated_ma_filter.sv
// Moving-average LPF/HPF with a modulated power-of-two window; a circular
// buffer plus running sum, rebuilt over the new window whenever it changes.
module modulated_ma_filter
  import synth_filter_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int MAX_LOG2_DEPTH = 6,
  parameter int CTRL_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] pcm_in,
  input  logic [1:0]               mode,
  input  logic [CTRL_W-1:0]        cutoff_freq,
  input  logic [CTRL_W-1:0]        eg_amount,
  input  logic [CTRL_W-1:0]        envelope,
  input  logic [CTRL_W-1:0]        modulation,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] pcm_out
);

  localparam int DEPTH = 1 << MAX_LOG2_DEPTH;
  localparam int LOG_W = $clog2(MAX_LOG2_DEPTH + 1);
  localparam int PTR_W = MAX_LOG2_DEPTH;
  localparam int SUM_W = DATA_W + MAX_LOG2_DEPTH;

  filt_state_e              state;
  filt_mode_e               mode_q;
  logic signed [DATA_W-1:0] sample_buf [DEPTH];
  logic signed [DATA_W-1:0] sample_q;
  logic signed [DATA_W-1:0] oldest_q;
  logic signed [SUM_W-1:0]  sum;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W:0]           idx;
  logic [LOG_W-1:0]         cur_log2;
  logic [LOG_W-1:0]         new_log2_q;
  logic [LOG_W-1:0]         new_log2;

  logic [PTR_W:0]           win_len;
  logic [PTR_W-1:0]         oldest_idx;
  logic [PTR_W-1:0]         recalc_idx;
  logic signed [SUM_W-1:0]  sample_ext;
  logic signed [SUM_W-1:0]  oldest_ext;
  logic signed [SUM_W-1:0]  recalc_ext;
  logic signed [DATA_W-1:0] lpf;
  logic signed [DATA_W-1:0] pcm_next;

  cutoff_modulator #(
    .CTRL_W         (CTRL_W),
    .MAX_LOG2_DEPTH (MAX_LOG2_DEPTH)
  ) u_cutoff_modulator (
    .cutoff_freq (cutoff_freq),
    .eg_amount   (eg_amount),
    .envelope    (envelope),
    .modulation  (modulation),
    .new_log2    (new_log2)
  );

  assign in_ready = (state == IDLE);

  // Pointer subtraction truncates to PTR_W bits, which is the modulo-DEPTH wrap;
  // a full-depth window therefore points at the slot about to be overwritten.
  assign win_len    = (PTR_W + 1)'(1) << new_log2_q;
  assign oldest_idx = wr_ptr - PTR_W'(win_len);
  assign recalc_idx = wr_ptr - PTR_W'(idx);

  assign sample_ext = {{MAX_LOG2_DEPTH{sample_q[DATA_W-1]}}, sample_q};
  assign oldest_ext = {{MAX_LOG2_DEPTH{oldest_q[DATA_W-1]}}, oldest_q};
  assign recalc_ext = {{MAX_LOG2_DEPTH{sample_buf[recalc_idx][DATA_W-1]}}, sample_buf[recalc_idx]};

  assign lpf = DATA_W'(sum >>> cur_log2);

  always_comb begin
    pcm_next = sample_q;
    unique case (mode_q)
      LPF:     pcm_next = lpf;
      HPF:     pcm_next = DATA_W'(sat_add(longint'(sample_q), -longint'(lpf), DATA_W));
      default: pcm_next = sample_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mode_q     <= BYPASS;
      sample_q   <= '0;
      oldest_q   <= '0;
      sum        <= '0;
      wr_ptr     <= '0;
      idx        <= '0;
      cur_log2   <= LOG_W'(MAX_LOG2_DEPTH);
      new_log2_q <= LOG_W'(MAX_LOG2_DEPTH);
      pcm_out    <= '0;
      out_valid  <= 1'b0;
      // NOTE: the buffer is cleared on reset because the running sum assumes
      // all history is zero; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) sample_buf[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sample_q   <= pcm_in;
            mode_q     <= filt_mode_e'(mode);
            new_log2_q <= new_log2;
            state      <= CALC;
          end
        end
        CALC: begin
          if (new_log2_q == cur_log2) begin
            oldest_q <= sample_buf[oldest_idx];
            state    <= UPDATE;
          end else begin
            sample_buf[wr_ptr] <= sample_q;
            sum                <= '0;
            idx                <= '0;
            state              <= RECALC;
          end
        end
        UPDATE: begin
          sum                <= sum + sample_ext - oldest_ext;
          sample_buf[wr_ptr] <= sample_q;
          wr_ptr             <= wr_ptr + PTR_W'(1);
          state              <= OUT;
        end
        RECALC: begin
          if (idx == win_len) begin
            cur_log2 <= new_log2_q;
            wr_ptr   <= wr_ptr + PTR_W'(1);
            state    <= OUT;
          end else begin
            sum <= sum + recalc_ext;
            idx <= idx + (PTR_W + 1)'(1);
          end
        end
        OUT: begin
          pcm_out   <= pcm_next;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modulated_ma_filter.sv
// Scoreboard bench for modulated_ma_filter: the driver queues hand-computed
// results with their latency, a monitor pops and checks on every out_valid.
module tb_modulated_ma_filter;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] pcm_in;
  logic [1:0]         mode;
  logic [15:0]        cutoff_freq;
  logic [15:0]        eg_amount;
  logic [15:0]        envelope;
  logic [15:0]        modulation;
  logic               out_valid;
  logic signed [15:0] pcm_out;

  typedef struct {
    logic signed [15:0] val;
    int                 acc;
    int                 lat;
    int                 id;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  modulated_ma_filter #(
    .DATA_W         (16),
    .MAX_LOG2_DEPTH (6),
    .CTRL_W         (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pcm_in      (pcm_in),
    .mode        (mode),
    .cutoff_freq (cutoff_freq),
    .eg_amount   (eg_amount),
    .envelope    (envelope),
    .modulation  (modulation),
    .out_valid   (out_valid),
    .pcm_out     (pcm_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive one sample; if want_out, queue its expected result and latency.
  task automatic send(input int id, input logic signed [15:0] s, input logic [1:0] m,
                      input logic [15:0] cut, input logic [15:0] eg, input logic [15:0] env,
                      input logic [15:0] modv, input logic signed [15:0] exp_v,
                      input int lat, input bit want_out);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check($sformatf("ready_timeout%0d", id), int'(in_ready), 1);
    pcm_in      = s;
    mode        = m;
    cutoff_freq = cut;
    eg_amount   = eg;
    envelope    = env;
    modulation  = modv;
    in_valid    = 1'b1;
    if (want_out) begin
      e.val = exp_v;
      e.acc = cyc + 1;
      e.lat = lat;
      e.id  = id;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Monitor: every result must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", int'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("out%0d_val", e.id), int'(pcm_out), int'(e.val));
          check($sformatf("out%0d_lat", e.id), cyc - e.acc, e.lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d results outstanding, expected 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    pcm_in = '0;
    mode = 2'd1;
    cutoff_freq = '0;
    eg_amount = '0;
    envelope = '0;
    modulation = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_pcm_out", int'(pcm_out), 0);

    // N=1 from reset: first sample rebuilds (latency 4), then latency 3.
    send(1, 16'sh1234, 2'd1, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'sh1234, 4, 1'b1);
    // Strobes while busy must be dropped.
    pcm_in   = 16'sh7777;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    send(2, -16'sh0800, 2'd1, 16'hFFFF, 16'h0, 16'h0, 16'h0, -16'sh0800, 3, 1'b1);
    drain();

    // Window grows to 64: reset in the middle of the rebuild aborts it.
    send(3, 16'sh1111, 2'd1, 16'h0000, 16'h0, 16'h0, 16'h0, 16'sh0, 0, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_pcm_out", int'(pcm_out), 0);

    // LPF N=64 constant 0x4000 on a zeroed buffer: k-th output is k*0x100.
    for (int k = 1; k <= 66; k++)
      send(100 + k, 16'sh4000, 2'd1, 16'h0000, 16'h0, 16'h0, 16'h0,
           16'((k > 64 ? 64 : k) * 16'h0100), 3, 1'b1);

    // HPF 0x2000 replacing 0x4000 history: lpf = 0x4000 - j*0x80, out = sample - lpf.
    for (int j = 1; j <= 64; j++)
      send(200 + j, 16'sh2000, 2'd2, 16'h0000, 16'h0, 16'h0, 16'h0,
           16'(-32'sh2000 + j * 32'sh80), 3, 1'b1);

    // HPF saturation: -0x8000 at N=1, then 0x7FFF at N=2: 0x7FFF - (-1) clips.
    send(301, -16'sh8000, 2'd2, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'sh0, 4, 1'b1);
    send(302, 16'sh7FFF, 2'd2, 16'hA000, 16'h0, 16'h0, 16'h0, 16'sh7FFF, 5, 1'b1);
    send(303, 16'sh5555, 2'd3, 16'hA000, 16'h0, 16'h0, 16'h0, 16'sh5555, 3, 1'b1);
    send(304, -16'sh1111, 2'd0, 16'hA000, 16'h0, 16'h0, 16'h0, -16'sh1111, 3, 1'b1);
    drain();

    // Window 64 -> 4 on the fourth sample: (1+2+3+4)>>2 = 2, latency 3+4.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(401, 16'sd1, 2'd1, 16'h0000, 16'h0, 16'h0, 16'h0, 16'sd0, 3, 1'b1);
    send(402, 16'sd2, 2'd1, 16'h0000, 16'h0, 16'h0, 16'h0, 16'sd0, 3, 1'b1);
    send(403, 16'sd3, 2'd1, 16'h0000, 16'h0, 16'h0, 16'h0, 16'sd0, 3, 1'b1);
    send(404, 16'sd4, 2'd1, 16'h8000, 16'h0, 16'h0, 16'h0, 16'sd2, 7, 1'b1);

    // Cutoff clamping and envelope term, observed through window length.
    send(501, 16'sd100, 2'd1, 16'hF000, 16'h0, 16'h0, 16'h7FFF, 16'sd100, 4, 1'b1);
    // 4096+100+4+3+2+1 = 4206, >>6 = 65
    send(502, 16'sd4096, 2'd1, 16'h1000, 16'h0, 16'h0, 16'h8000, 16'sd65, 67, 1'b1);
    send(503, -16'sd5, 2'd1, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0, -16'sd5, 4, 1'b1);
    // 0x4000 + (0x8000*0x8000>>16) = 0x8000 -> N=4: (9-5+4096+100)>>2 = 1050
    send(504, 16'sd9, 2'd1, 16'h4000, 16'h8000, 16'h8000, 16'h0, 16'sd1050, 7, 1'b1);
    // 4200-9001-100 = -4901, >>>2 floors to -1226
    send(505, -16'sd9001, 2'd1, 16'h4000, 16'h8000, 16'h8000, 16'h0, -16'sd1226, 3, 1'b1);
    drain();

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
